// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with req/ack imem interface, one-word skid buffer and IF/ID register.
// Stale words from a redirected request are dropped; bubbles fill IF/ID while imem is slow.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_f_i,
    input  logic        stall_d_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_f_o,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc_plus_4_d_o,
    output logic        valid_d_o
);
    typedef enum logic [1:0] {S_REQ, S_HOLD, S_DROP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_f_q, pc_f_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic [31:0] instr_d_q, instr_d_d;
    logic [31:0] pc4_d_q, pc4_d_d;
    logic        valid_d_q, valid_d_d;
    logic        go, redir, xfer, deliver;
    logic [31:0] del_instr, del_pc4, pc_inc;

    assign go     = !stall_f_i && !stall_d_i;
    assign redir  = redirect_i && go;
    assign xfer   = imem_req_o && imem_ack_i;
    assign pc_inc = pc_f_q + 32'd4;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_REQ;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_REQ:   state_d = (redir && !xfer) ? S_DROP : (!go && xfer) ? S_HOLD : S_REQ;
            S_HOLD:  state_d = go ? S_REQ : S_HOLD;
            S_DROP:  state_d = xfer ? S_REQ : S_DROP;
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        imem_req_o = (state_q == S_REQ || state_q == S_DROP) && !rst_i;
    end

    always_comb begin
        pc_f_d       = pc_f_q;
        req_addr_d   = req_addr_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        deliver      = 1'b0;
        del_instr    = imem_rdata_i;
        del_pc4      = pc_inc;
        case (state_q)
            S_REQ: begin
                if (redir) begin
                    pc_f_d     = redirect_pc_i;
                    req_addr_d = xfer ? redirect_pc_i : req_addr_q;
                end else if (xfer && go) begin
                    deliver    = 1'b1;
                    pc_f_d     = pc_inc;
                    req_addr_d = pc_inc;
                end else if (xfer) begin
                    skid_instr_d = imem_rdata_i;
                    skid_pc4_d   = pc_inc;
                end
            end
            S_HOLD: begin
                if (redir) begin
                    pc_f_d     = redirect_pc_i;
                    req_addr_d = redirect_pc_i;
                end else if (go) begin
                    deliver    = 1'b1;
                    del_instr  = skid_instr_q;
                    del_pc4    = skid_pc4_q;
                    pc_f_d     = pc_inc;
                    req_addr_d = pc_inc;
                end
            end
            S_DROP: begin
                // A redirect landing with the stale ack wins: re-request the newest target.
                pc_f_d     = redir ? redirect_pc_i : pc_f_q;
                req_addr_d = xfer ? pc_f_d : req_addr_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        instr_d_d = stall_d_i ? instr_d_q : deliver ? del_instr : 32'h0;
        pc4_d_d   = stall_d_i ? pc4_d_q   : deliver ? del_pc4   : 32'h0;
        valid_d_d = stall_d_i ? valid_d_q : deliver;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pc_f_q       <= RESET_PC;
            req_addr_q   <= RESET_PC;
            skid_instr_q <= 32'h0;
            skid_pc4_q   <= 32'h0;
            instr_d_q    <= 32'h0;
            pc4_d_q      <= 32'h0;
            valid_d_q    <= 1'b0;
        end else begin
            pc_f_q       <= pc_f_d;
            req_addr_q   <= req_addr_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            instr_d_q    <= instr_d_d;
            pc4_d_q      <= pc4_d_d;
            valid_d_q    <= valid_d_d;
        end
    end

    assign imem_addr_o   = req_addr_q;
    assign pc_f_o        = pc_f_q;
    assign instr_d_o     = instr_d_q;
    assign pc_plus_4_d_o = pc4_d_q;
    assign valid_d_o     = valid_d_q;
endmodule
